// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-wide DataMemory.
// Accepts byte-addressed loads and stores. Byte and halfword stores are done
// as read-modify-write because the memory only writes whole words.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t             r_state;
  state_t             w_next;

  logic               r_write;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [1:0]         r_lane;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_wdata;
  logic [31:0]        r_merged;
  logic               r_resp_valid;
  logic               r_resp_err;
  logic [31:0]        r_resp_rdata;

  logic               w_accept;
  logic               w_err;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [31:0]        w_merge;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  // Request legality: illegal size, misalignment, or word index beyond memory
  always_comb begin
    w_err = 1'b0;
    case (req_size)
      2'd1:    w_err = req_addr[0];
      2'd2:    w_err = |req_addr[1:0];
      2'd3:    w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
    if (32'(req_addr[31:2]) >= MEM_WORDS) w_err = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_err)
                w_next = (req_write && req_size == 2'd2) ? S_WR : S_RD;
      S_RD:   w_next = r_write ? S_WR : S_IDLE;
      S_WR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and memory port decode, purely from state
  always_comb begin
    req_ready = (r_state == S_IDLE);
    mem_read  = (r_state == S_RD);
    mem_write = (r_state == S_WR);
    mem_addr  = (r_state == S_IDLE) ? '0 : 32'(r_idx);
    mem_wdata = (r_state == S_WR) ? r_merged : '0;
  end

  // Load lane selection and sign/zero extension of the word read in RD
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'd0:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Sub-word store merge into the word read in RD
  always_comb begin
    w_merge = mem_rdata;
    if (r_size == 2'd0) begin
      case (r_lane)
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_size == 2'd1) begin
      if (r_lane[1]) w_merge[31:16] = r_wdata;
      else           w_merge[15:0]  = r_wdata;
    end
  end

  // Request latch, write-data staging and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_lane       <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_merged     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_write  <= req_write;
          r_size   <= req_size;
          r_signed <= req_signed;
          r_lane   <= req_addr[1:0];
          r_idx    <= req_addr[IDX_W+1:2];
          r_wdata  <= req_wdata[15:0];
          // Word stores write this directly; sub-word stores overwrite it in RD
          r_merged <= req_wdata;
          if (w_err) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end
        end
        S_RD: begin
          if (r_write) begin
            r_merged <= w_merge;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
          end
        end
        S_WR: r_resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural DataMemory and a
// byte-mask reference model of memory contents.
module tb_lsu_mem_ctrl;

  localparam int unsigned MW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(MW), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DataMemory stand-in: combinational read, write on clock edge.
  // A garbage pattern stands in for Z when not reading.
  logic [31:0] dmem [MW];
  logic        mem_init = 1'b0;
  assign mem_rdata = mem_read ? dmem[mem_addr[7:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MW); i++) dmem[i] <= 32'(i);
    end else if (mem_write && !mem_read) begin
      dmem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    int unsigned idx;
    logic [31:0] wword;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [MW];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on resp_valid and tracks memory activity per request
  int cyc = 0, acc_cyc = 0, nrd = 0, nwr = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (resp_valid) begin
        check("ready_on_resp", 32'(req_ready), 32'd1);
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got resp_valid=1, want no response pending");
        end else begin
          e = q.pop_front();
          check("resp_err",   32'(resp_err), 32'(e.err));
          check("resp_rdata", resp_rdata, e.rdata);
          check("latency",    32'(cyc - acc_cyc), 32'(e.lat));
          check("num_reads",  32'(nrd), 32'(e.nrd));
          check("num_writes", 32'(nwr), 32'(e.nwr));
        end
      end
      check("rd_wr_excl", 32'(mem_read && mem_write), 32'd0);
      if (mem_read || mem_write) begin
        if (mem_read)  nrd++;
        if (mem_write) nwr++;
        if (q.size() > 0) begin
          check("mem_addr", mem_addr, 32'(q[$].idx));
          if (mem_write) check("mem_wdata", mem_wdata, q[$].wword);
        end
      end else begin
        check("idle_addr", mem_addr, 32'd0);
      end
      if (!mem_write) check("idle_wdata", mem_wdata, 32'd0);
      if (req_valid && req_ready) begin
        acc_cyc = cyc; nrd = 0; nwr = 0;
      end
    end
  end

  // Issue one request; on acceptance push the reference expectation
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input bit track,
                       output int waits, output logic rv_at_acc);
    exp_t        e;
    int unsigned idx, nb, sh;
    logic [63:0] m;
    logic [31:0] val, old;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    @(negedge clk);
    waits = 0;
    while (!req_ready && waits < 10) begin @(negedge clk); waits++; end
    rv_at_acc = resp_valid;
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got req_ready=0, want 1 within 10 cycles");
    end else if (track) begin
      idx = a >> 2;
      nb  = 1 << sz;
      sh  = 8 * (a % 4);
      e.idx = idx; e.rdata = '0; e.wword = '0; e.nrd = 0; e.nwr = 0;
      e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (idx >= MW);
      if (e.err) begin
        e.lat = 1;
      end else begin
        m = (64'd1 << (8 * nb)) - 64'd1;
        if (!w) begin
          val = ref_mem[idx] >> sh;
          val = val & m[31:0];
          if (sg && ((val >> (8 * nb - 1)) & 32'd1) == 32'd1) val = val | ~m[31:0];
          e.rdata = val; e.lat = 2; e.nrd = 1;
        end else begin
          old = ref_mem[idx];
          m = m << sh;
          e.wword = (old & ~m[31:0]) | ((d << sh) & m[31:0]);
          ref_mem[idx] = e.wword;
          e.nwr = 1;
          e.nrd = (nb < 4) ? 1 : 0;
          e.lat = (nb < 4) ? 3 : 2;
        end
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rq(input logic w, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] d);
    int wt; logic rv;
    issue(w, sz, sg, a, d, 1'b1, wt, rv);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt; logic rv;
    logic [1:0] sz; logic [31:0] a;
    for (int i = 0; i < int'(MW); i++) ref_mem[i] = 32'(i);
    mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rerr",   32'(resp_err),   32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_mread",  32'(mem_read),   32'd0);
    check("rst_mwrite", 32'(mem_write),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_mread",  32'(mem_read),  32'd0);
      check("idle_mwrite", 32'(mem_write), 32'd0);
      check("idle_ready",  32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;

    rq(1, 2, 0, 32'h0, 32'hAAAA_AAAA);
    rq(0, 2, 0, 32'h0, 32'h0);
    rq(1, 0, 0, 32'h3D, 32'h5A);
    rq(0, 0, 0, 32'h3D, 32'h0);
    rq(1, 0, 0, 32'h3E, 32'h80);
    rq(0, 0, 1, 32'h3E, 32'h0);
    rq(0, 0, 0, 32'h3E, 32'h0);
    rq(0, 1, 1, 32'h3E, 32'h0);
    rq(0, 2, 0, 32'h3C, 32'h0);
    rq(0, 2, 0, 32'h02, 32'h0);
    rq(0, 1, 0, 32'h05, 32'h0);
    rq(0, 3, 0, 32'h00, 32'h0);
    rq(0, 2, 0, 32'h400, 32'h0);

    // Reset during the read phase of a byte store: the write must never happen
    issue(1, 0, 0, 32'h04, 32'hFF, 1'b0, wt, rv);
    #2;
    check("rd_phase_before_rst", 32'(mem_read), 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_async_mread",  32'(mem_read),  32'd0);
    check("rst_async_mwrite", 32'(mem_write), 32'd0);
    check("rst_async_maddr",  mem_addr,       32'd0);
    check("rst_async_ready",  32'(req_ready), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_hold_mwrite", 32'(mem_write), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rq(0, 2, 0, 32'h04, 32'h0);

    // Back-to-back loads with req_valid held
    issue(0, 2, 0, 32'h08, 32'h0, 1'b1, wt, rv);
    issue(0, 2, 0, 32'h0C, 32'h0, 1'b1, wt, rv);
    check("b2b_wait_cycles", 32'(wt), 32'd1);
    check("b2b_accept_on_resp", 32'(rv), 32'd1);
    idle(1);

    for (int n = 0; n < 400; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom();
      else a = $urandom_range(0, 32'h3FF);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), 1'b1, wt, rv);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
    idle(6);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller directly upstream of DataMemory. It accepts byte-addressed load/store requests from the execute stage and drives DataMemory's word-wide addr/read/write/mem_in port. It returns formatted load data on mem_out. Byte and halfword stores are done as read-modify-write, because DataMemory only writes whole 32-bit words.

Parameters:
MEM_WORDS, 256, number of 32-bit words in DataMemory; word index >= MEM_WORDS is out of range
IDX_W, 8, width of the word index driven on mem_addr, equal to clog2(MEM_WORDS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  in  1  sign-extend load result
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: misaligned, illegal size or out of range
resp_rdata  out  32  formatted load data; 0 for stores and errors
mem_addr  out  32  word index to DataMemory (req_addr[IDX_W+1:2], zero-extended)
mem_read  out  1  DataMemory read enable (ENABLE/DISABLE)
mem_write  out  1  DataMemory write enable
mem_wdata  out  32  to DataMemory mem_in
mem_rdata  in  32  from DataMemory mem_out; Z when mem_read is low

Behaviour:
- DataMemory contract:
  - Read is combinational on mem_addr while mem_read is high.
  - A write commits on the rising clk edge while mem_write is high.
  - mem_read and mem_write are never high together.
- States: IDLE, RD, WR.
  - req_ready = (state == IDLE).
  - mem_read = (state == RD).
  - mem_write = (state == WR).
  - All three are decoded combinationally from state.
- Accept (IDLE, req_valid high, at a clk edge):
  - Latch the request.
  - Error if any of: size 3; half with addr[0] = 1; word with addr[1:0] != 0; word index >= MEM_WORDS.
    - Stay in IDLE. Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0. No memory access.
  - Load, or sub-word store: go to RD.
  - Word store: go to WR.
- RD:
  - mem_addr = latched index.
  - At the edge, capture mem_rdata.
  - Load: format the data, go to IDLE, resp_valid next cycle.
  - Sub-word store: build the merged word, go to WR.
- Load formatting:
  - Byte lane = addr[1:0]. Halfword lane = addr[1].
  - Sign-extend if req_signed, else zero-extend.
  - Word loads pass through unchanged.
- Store merge: replace only the addressed byte/half of the captured word with req_wdata[7:0] or [15:0]. Other bytes are preserved.
- WR:
  - mem_wdata = merged word, or req_wdata for word stores.
  - One cycle long. Go to IDLE; resp_valid = 1 next cycle with resp_rdata = 0.
- Latency, from accept edge to resp_valid cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- resp_valid is a registered single-cycle pulse with no backpressure. A new request may be accepted in the same cycle resp_valid is high.
- Idle driving:
  - mem_addr = 0 when in IDLE, latched index otherwise.
  - mem_wdata = 0 outside WR.
  - mem_rdata is sampled only in RD, so Z elsewhere is harmless.
- Reset (rst_n low, asynchronously):
  - state = IDLE.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - All latched request fields = 0.
  - mem_read, mem_write, mem_addr and mem_wdata go to 0 immediately.
  - Reset mid-RMW never produces a partial write. An in-flight request is dropped with no response.
- req_valid while req_ready is low is ignored; upstream must hold it.

Test Plan:
1. Reset, then release -> all outputs 0, req_ready = 1; mem_read/mem_write stay 0 with req_valid = 0 for 5 cycles.
2. DataMemory preloaded word i = i. Word store 0xAAAAAAAA at byte addr 0x0, then word load at 0x0:
   - Store: mem_write for exactly 1 cycle with mem_addr = 0; resp 2 cycles after accept.
   - Load: resp_rdata = 0xAAAAAAAA, 2 cycles after accept.
3. Byte store 0x5A to addr 0x3D:
   - RD of word 0xF reads 0x0000000F; WR drives mem_wdata 0x00005A0F; resp 3 cycles after accept.
   - Then unsigned byte load at 0x3D -> 0x0000005A.
4. Byte store 0x80 to 0x3E, then:
   - Signed byte load at 0x3E -> 0xFFFFFF80.
   - Unsigned byte load at 0x3E -> 0x00000080.
   - Signed half load at 0x3E -> 0x00000080.
   - Word load at 0x3C -> 0x00805A0F.
5. Errors:
   - Word load at 0x02 -> resp_err = 1, 1 cycle after accept.
   - Half load at 0x05 -> resp_err = 1.
   - Size 3 -> resp_err = 1.
   - Load at byte addr 0x400 (index 256) -> resp_err = 1.
   - In all cases mem_read/mem_write never assert.
6. Reset mid-operation and back-to-back:
   - Assert rst_n low during RD of a byte store to 0x04 -> mem_write never asserts; word 1 still reads 0x00000001.
   - Two loads with req_valid held high -> req_ready low for 1 cycle; second request accepted in the cycle the first resp_valid is high.
